dmem_ctrl: RTL

- MEM-stage load/store unit; the responder side of the decoder's mem_read/mem_write/mem_to_reg control interface.
- Turns each load/store into a req/gnt/rvalid transaction on the data-memory bus.
- Stalls the pipeline until the transaction completes, and returns aligned, sign/zero-extended load data to the MEM/WB register.

---
 rtl/riscv_pkg.sv | 54 +++++
 rtl/dmem_lane_align.sv | 59 +++++
 rtl/dmem_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the MEM-stage load/store unit.
// Contents:
//   - opcode constants and funct3 load/store size encodings
//   - dmem FSM state enum and the latched request struct
//   - helpers that classify an access as illegal or misaligned
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dmem_state_e;

  // Everything the bus needs is frozen here for the whole transaction.
  typedef struct packed {
    logic                               we;
    logic [29:0]                        waddr;
    logic [NUM_LANES-1:0]               be;
    logic [NUM_LANES-1:0][LANE_W-1:0]   wdata;
    logic [2:0]                         f3;
    logic [1:0]                         lo;
  } dmem_req_t;

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W) &&
           (f3 != F3_BU) && (f3 != F3_HU);
  endfunction

  // Size lives in f3[1:0]; signedness bit f3[2] does not affect alignment.
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (f3[1:0])
      F3_H[1:0]: bad = lo[0];
      F3_W[1:0]: bad = (lo != 2'b00);
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data-memory port.
// Ports:
//   st_f3/st_lo/st_wdata -> st_be/st_wdata_rep : store byte enables and
//                                                lane-replicated write data
//   ld_f3/ld_lo/ld_word  -> ld_val             : load byte/half select with
//                                                sign or zero extension
module dmem_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]                        st_f3,
  input  logic [1:0]                        st_lo,
  input  logic [31:0]                       st_wdata,
  output logic [NUM_LANES-1:0]              st_be,
  output logic [NUM_LANES-1:0][LANE_W-1:0]  st_wdata_rep,
  input  logic [2:0]                        ld_f3,
  input  logic [1:0]                        ld_lo,
  input  logic [31:0]                       ld_word,
  output logic [31:0]                       ld_val
);

  // Per-lane store steering: bytes broadcast to all lanes, halves to both
  // half-word slots, words pass straight through.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    always_comb begin
      case (st_f3[1:0])
        F3_B[1:0]: begin
          st_wdata_rep[i] = st_wdata[7:0];
          st_be[i]        = (st_lo == 2'(i));
        end
        F3_H[1:0]: begin
          st_wdata_rep[i] = st_wdata[LANE_W*(i%2) +: LANE_W];
          st_be[i]        = (st_lo[1] == 1'(i/2));
        end
        default: begin
          st_wdata_rep[i] = st_wdata[LANE_W*i +: LANE_W];
          st_be[i]        = 1'b1;
        end
      endcase
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_sx;

  assign ld_byte = ld_word[{ld_lo, 3'b000} +: 8];
  assign ld_half = ld_word[{ld_lo[1], 4'b0000} +: 16];
  assign ld_sx   = ~ld_f3[2];

  always_comb begin
    ld_val = ld_word;
    case (ld_f3[1:0])
      F3_B[1:0]: ld_val = {{24{ld_sx & ld_byte[7]}}, ld_byte};
      F3_H[1:0]: ld_val = {{16{ld_sx & ld_half[15]}}, ld_half};
      default:   ld_val = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage load/store unit. Turns mem_read/mem_write into one req/gnt/rvalid
// bus transaction, stalls the pipeline until it completes, and hands aligned,
// extended load data to MEM/WB.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   mem_read, mem_write, funct3,
//   addr, wdata                       access from the MEM stage
//   rdata, stall, misalign, bus_err   results back to the pipeline
//   bus_req/we/addr/wdata/be          request side of the data bus
//   bus_gnt, bus_rvalid, bus_rdata    response side of the data bus
module dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            stall,
  output logic            misalign,
  output logic            bus_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_be,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  dmem_state_e          state_q, state_d;
  dmem_req_t            req_q;
  logic [CW-1:0]        cnt_q;
  logic [XLEN-1:0]      rdata_q;

  logic                 access, bad_acc, tmo_hit;
  logic                 latch, cap_load, cap_zero, cnt_clr;
  logic [NUM_LANES-1:0] st_be;
  logic [NUM_LANES-1:0][LANE_W-1:0] st_wdata_rep;
  logic [31:0]          ld_val;

  assign access  = mem_read | mem_write;
  assign bad_acc = f3_illegal(funct3) | addr_misaligned(funct3, addr[1:0]);
  // With TIMEOUT=0 the counter free-runs but never aborts.
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

  dmem_lane_align u_align (
    .st_f3        (funct3),
    .st_lo        (addr[1:0]),
    .st_wdata     (wdata),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .ld_f3        (req_q.f3),
    .ld_lo        (req_q.lo),
    .ld_word      (bus_rdata),
    .ld_val       (ld_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    misalign = 1'b0;
    bus_err  = 1'b0;
    bus_req  = 1'b0;
    latch    = 1'b0;
    cap_load = 1'b0;
    cap_zero = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (bad_acc) begin
            misalign = 1'b1;
            cap_zero = 1'b1;
          end else begin
            stall   = 1'b1;
            latch   = 1'b1;
            cnt_clr = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (tmo_hit) begin
          // Abort wins over a same-cycle grant: req is already low.
          bus_err  = 1'b1;
          cap_zero = 1'b1;
          state_d  = ST_DONE;
        end else begin
          bus_req = 1'b1;
          if (bus_gnt) begin
            cnt_clr = 1'b1;
            state_d = req_q.we ? ST_DONE : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (tmo_hit) begin
          bus_err  = 1'b1;
          cap_zero = 1'b1;
          state_d  = ST_DONE;
        end else if (bus_rvalid) begin
          cap_load = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (latch) begin
        // Read wins when both strobes are up; loads use all lanes, no data.
        req_q.we    <= ~mem_read;
        req_q.waddr <= addr[XLEN-1:2];
        req_q.be    <= mem_read ? 4'hF : st_be;
        req_q.wdata <= mem_read ? '0 : st_wdata_rep;
        req_q.f3    <= funct3;
        req_q.lo    <= addr[1:0];
      end
      if (cap_load)      rdata_q <= ld_val;
      else if (cap_zero) rdata_q <= '0;
      if (cnt_clr)
        cnt_q <= '0;
      else if (state_q == ST_REQ || state_q == ST_WAIT)
        cnt_q <= cnt_q + CW'(1);
    end
  end

  // A faulting access advances the same cycle, so zero rdata combinationally.
  assign rdata     = misalign ? '0 : rdata_q;
  assign bus_we    = req_q.we;
  assign bus_addr  = {req_q.waddr, 2'b00};
  assign bus_be    = req_q.be;
  assign bus_wdata = req_q.wdata;

endmodule
